// File: rtl/fetch_inst_stage.sv
// Fetch stage: takes a PC from pre-fetch, issues a single-outstanding instruction-bus request, and presents {pc, inst} to decode.
// Optional build macro FETCH_ADEL_EN: misaligned PCs bypass the bus and are flagged on out_adel.
module fetch_inst_stage #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int          CANCEL_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pf_valid,
    input  logic [31:0] pf_pc,
    output logic        f_allowin,
    input  logic        flush,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        d_allowin,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_adel
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [CANCEL_W-1:0] CANCEL_MAX  = {CANCEL_W{1'b1}};
    localparam logic [CANCEL_W-1:0] CANCEL_ZERO = {CANCEL_W{1'b0}};
    localparam logic [CANCEL_W-1:0] CANCEL_ONE  = CANCEL_W'(1);

    state_t              state_r;
    state_t              state_s;
    logic [CANCEL_W-1:0] cancel_cnt_r;
    logic [31:0]         pc_r;
    logic [31:0]         inst_r;
    logic                accept_s;
    logic                capture_s;
    logic                cancel_inc_s;
    logic                cancel_dec_s;
    logic                misaligned_s;

    assign f_allowin    = (state_r == S_IDLE) || ((state_r == S_HOLD) && d_allowin);
    assign accept_s     = pf_valid && f_allowin && !flush;
    assign capture_s    = (state_r == S_WAIT) && inst_data_ok && (cancel_cnt_r == CANCEL_ZERO);
    assign cancel_dec_s = inst_data_ok && (cancel_cnt_r != CANCEL_ZERO);
    // A beat consumed in the flush cycle itself leaves nothing outstanding to cancel.
    assign cancel_inc_s = flush && (((state_r == S_WAIT) && !capture_s) ||
                                    ((state_r == S_REQ) && inst_addr_ok));

    assign inst_req  = (state_r == S_REQ);
    assign inst_addr = pc_r;
    assign out_valid = (state_r == S_HOLD);
    assign out_pc    = pc_r;
    assign out_inst  = (state_r == S_HOLD) ? inst_r : NOP_INST;

`ifdef FETCH_ADEL_EN
    logic adel_r;

    assign misaligned_s = (pf_pc[1:0] != 2'b00);
    assign out_adel     = adel_r && (state_r == S_HOLD);

    // Address-error flag follows the entry that raised it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            adel_r <= 1'b0;
        end else if (flush) begin
            adel_r <= 1'b0;
        end else if (accept_s) begin
            adel_r <= misaligned_s;
        end else if ((state_r == S_HOLD) && d_allowin) begin
            adel_r <= 1'b0;
        end
    end
`else
    assign misaligned_s = 1'b0;
    assign out_adel     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        state_s = misaligned_s ? S_HOLD : S_REQ;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_REQ: begin
                    if (inst_addr_ok) begin
                        state_s = S_WAIT;
                    end else begin
                        state_s = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (capture_s) begin
                        state_s = S_HOLD;
                    end else begin
                        state_s = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (accept_s) begin
                        state_s = misaligned_s ? S_HOLD : S_REQ;
                    end else if (d_allowin) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_HOLD;
                    end
                end
                default: state_s = S_IDLE;
            endcase
        end
    end

    // PC and instruction holding registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_r   <= 32'h0000_0000;
            inst_r <= NOP_INST;
        end else begin
            if (accept_s) begin
                pc_r <= pf_pc;
            end
            if (capture_s) begin
                inst_r <= inst_rdata;
            end else if (accept_s && misaligned_s) begin
                inst_r <= NOP_INST;
            end
        end
    end

    // Stale-response counter: in-order responses, so the next cancel_cnt beats are discarded.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cancel_cnt_r <= CANCEL_ZERO;
        end else if (cancel_inc_s && !cancel_dec_s && (cancel_cnt_r != CANCEL_MAX)) begin
            cancel_cnt_r <= cancel_cnt_r + CANCEL_ONE;
        end else if (cancel_dec_s && !cancel_inc_s) begin
            cancel_cnt_r <= cancel_cnt_r - CANCEL_ONE;
        end
    end

endmodule

// File: tb/tb_fetch_inst_stage.sv
// Scoreboard-driven bench for fetch_inst_stage: expected {pc, inst} pushed when the data beat is driven, popped on out_valid.
module tb_fetch_inst_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pf_valid;
    logic [31:0] pf_pc;
    logic        f_allowin;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        d_allowin;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_adel;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_v;

    fetch_inst_stage dut (
        .clk          (clk),
        .resetn       (resetn),
        .pf_valid     (pf_valid),
        .pf_pc        (pf_pc),
        .f_allowin    (f_allowin),
        .flush        (flush),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .d_allowin    (d_allowin),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .out_adel     (out_adel)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pop_exp();
        if (exp_q.size() == 0) return 64'bx;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        resetn = 1'b0; pf_valid = 1'b0; pf_pc = 32'h0; flush = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0; d_allowin = 1'b0;
        tick(); tick();
        tests_run++;
        if ({out_valid, inst_req, out_adel, f_allowin} !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got v/req/adel/allow=%b want 0001", {out_valid, inst_req, out_adel, f_allowin});
        end
        tests_run++;
        if ({out_pc, out_inst} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got pc=%h inst=%h want 0/0", out_pc, out_inst);
        end
        tests_run++;
        if (dut.cancel_cnt_r !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_cnt: got %0d want 0", dut.cancel_cnt_r);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        pf_valid = 1'b1; pf_pc = 32'hBFC0_0000; d_allowin = 1'b0;
        tick();
        pf_valid = 1'b0;
        tests_run++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0000) begin
            tests_failed++;
            $display("FAIL basic_req: got req=%b addr=%h want 1/bfc00000", inst_req, inst_addr);
        end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        tests_run++;
        if (inst_req !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_wait: got req=%b valid=%b want 0/0", inst_req, out_valid);
        end
        inst_data_ok = 1'b1; inst_rdata = 32'h2408_0001;
        exp_q.push_back({32'hBFC0_0000, 32'h2408_0001});
        tick();
        inst_data_ok = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || inst_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_hold: got valid=%b req=%b want 1/0", out_valid, inst_req);
        end
        exp_v = pop_exp();
        tests_run++;
        if ({out_pc, out_inst} !== exp_v) begin
            tests_failed++;
            $display("FAIL basic_data: got %h want %h", {out_pc, out_inst}, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || f_allowin !== 1'b0 || out_pc !== 32'hBFC0_0000 || out_inst !== 32'h2408_0001) begin
                tests_failed++;
                $display("FAIL stall_%0d: got valid=%b allow=%b pc=%h inst=%h want 1/0/bfc00000/24080001",
                         i, out_valid, f_allowin, out_pc, out_inst);
            end
        end
        d_allowin = 1'b1; pf_valid = 1'b1; pf_pc = 32'hBFC0_0004;
        #1;
        tests_run++;
        if (f_allowin !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_allow: got %b want 1", f_allowin);
        end
        tick();
        pf_valid = 1'b0; d_allowin = 1'b0;
        tests_run++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0004 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_req: got req=%b addr=%h valid=%b want 1/bfc00004/0", inst_req, inst_addr, out_valid);
        end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3C1D_0000;
        exp_q.push_back({32'hBFC0_0004, 32'h3C1D_0000});
        tick();
        inst_data_ok = 1'b0;
        exp_v = pop_exp();
        tests_run++;
        if (out_valid !== 1'b1 || {out_pc, out_inst} !== exp_v) begin
            tests_failed++;
            $display("FAIL b2b_data: got valid=%b %h want 1 %h", out_valid, {out_pc, out_inst}, exp_v);
        end
        d_allowin = 1'b1;
        tick();
        d_allowin = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0) begin
            tests_failed++;
            $display("FAIL b2b_drain: got valid=%b inst=%h want 0/0", out_valid, out_inst);
        end
    endtask

    task automatic test_flush_wait();
        pf_valid = 1'b1; pf_pc = 32'h8000_0000;
        tick();
        pf_valid = 1'b0; inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || inst_req !== 1'b0 || dut.cancel_cnt_r !== 2'd1) begin
            tests_failed++;
            $display("FAIL fw_flush: got valid=%b req=%b cnt=%0d want 0/0/1", out_valid, inst_req, dut.cancel_cnt_r);
        end
        pf_valid = 1'b1; pf_pc = 32'h8000_0180;
        tick();
        pf_valid = 1'b0;
        tests_run++;
        if (inst_req !== 1'b1 || inst_addr !== 32'h8000_0180) begin
            tests_failed++;
            $display("FAIL fw_req: got req=%b addr=%h want 1/80000180", inst_req, inst_addr);
        end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || dut.cancel_cnt_r !== 2'd0) begin
            tests_failed++;
            $display("FAIL fw_stale: got valid=%b cnt=%0d want 0/0", out_valid, dut.cancel_cnt_r);
        end
        inst_rdata = 32'h1234_5678;
        exp_q.push_back({32'h8000_0180, 32'h1234_5678});
        tick();
        inst_data_ok = 1'b0;
        exp_v = pop_exp();
        tests_run++;
        if (out_valid !== 1'b1 || {out_pc, out_inst} !== exp_v || dut.cancel_cnt_r !== 2'd0) begin
            tests_failed++;
            $display("FAIL fw_data: got valid=%b %h cnt=%0d want 1 %h 0", out_valid, {out_pc, out_inst}, dut.cancel_cnt_r, exp_v);
        end
        d_allowin = 1'b1;
        tick();
        d_allowin = 1'b0;
    endtask

    task automatic test_double_flush();
        pf_valid = 1'b1; pf_pc = 32'h8000_1000;
        tick();
        pf_valid = 1'b0; inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; pf_valid = 1'b1; pf_pc = 32'h8000_1004;
        tick();
        pf_valid = 1'b0; inst_addr_ok = 1'b1; flush = 1'b1;
        tick();
        inst_addr_ok = 1'b0; flush = 1'b0;
        tests_run++;
        if (dut.cancel_cnt_r !== 2'd2 || inst_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL df_cnt: got cnt=%0d req=%b want 2/0", dut.cancel_cnt_r, inst_req);
        end
        pf_valid = 1'b1; pf_pc = 32'h8000_1008;
        tick();
        pf_valid = 1'b0; inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            inst_rdata = 32'h1111_0000 + i;
            tick();
            tests_run++;
            if (out_valid !== 1'b0 || dut.cancel_cnt_r !== 2'(1 - i)) begin
                tests_failed++;
                $display("FAIL df_drop_%0d: got valid=%b cnt=%0d want 0/%0d", i, out_valid, dut.cancel_cnt_r, 1 - i);
            end
        end
        inst_rdata = 32'hCAFE_F00D;
        exp_q.push_back({32'h8000_1008, 32'hCAFE_F00D});
        tick();
        inst_data_ok = 1'b0;
        exp_v = pop_exp();
        tests_run++;
        if (out_valid !== 1'b1 || {out_pc, out_inst} !== exp_v) begin
            tests_failed++;
            $display("FAIL df_data: got valid=%b %h want 1 %h", out_valid, {out_pc, out_inst}, exp_v);
        end
        d_allowin = 1'b1;
        tick();
        d_allowin = 1'b0;
    endtask

    task automatic test_addr_stall();
        pf_valid = 1'b1; pf_pc = 32'h9FC0_0010;
        tick();
        pf_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (inst_req !== 1'b1 || inst_addr !== 32'h9FC0_0010) begin
                tests_failed++;
                $display("FAIL stall_req_%0d: got req=%b addr=%h want 1/9fc00010", i, inst_req, inst_addr);
            end
            if (i == 2) flush = 1'b1;
            tick();
        end
        flush = 1'b0;
        tests_run++;
        if (inst_req !== 1'b0 || f_allowin !== 1'b1 || dut.cancel_cnt_r !== 2'd0) begin
            tests_failed++;
            $display("FAIL stall_flush: got req=%b allow=%b cnt=%0d want 0/1/0", inst_req, f_allowin, dut.cancel_cnt_r);
        end
        inst_data_ok = 1'b1; inst_rdata = 32'hFFFF_FFFF;
        tick();
        inst_data_ok = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || f_allowin !== 1'b1 || dut.cancel_cnt_r !== 2'd0) begin
            tests_failed++;
            $display("FAIL proto_err: got valid=%b allow=%b cnt=%0d want 0/1/0", out_valid, f_allowin, dut.cancel_cnt_r);
        end
    endtask

    task automatic test_adel();
        pf_valid = 1'b1; pf_pc = 32'hBFC0_0002;
        tick();
        pf_valid = 1'b0;
`ifdef FETCH_ADEL_EN
        tests_run++;
        if (inst_req !== 1'b0 || out_valid !== 1'b1 || out_adel !== 1'b1 ||
            out_inst !== 32'h0 || out_pc !== 32'hBFC0_0002) begin
            tests_failed++;
            $display("FAIL adel_hold: got req=%b valid=%b adel=%b inst=%h pc=%h want 0/1/1/0/bfc00002",
                     inst_req, out_valid, out_adel, out_inst, out_pc);
        end
        d_allowin = 1'b1;
        tick();
        d_allowin = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || out_adel !== 1'b0) begin
            tests_failed++;
            $display("FAIL adel_clear: got valid=%b adel=%b want 0/0", out_valid, out_adel);
        end
`else
        tests_run++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0002 || out_adel !== 1'b0) begin
            tests_failed++;
            $display("FAIL adel_req: got req=%b addr=%h adel=%b want 1/bfc00002/0", inst_req, inst_addr, out_adel);
        end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h8C02_0000;
        exp_q.push_back({32'hBFC0_0002, 32'h8C02_0000});
        tick();
        inst_data_ok = 1'b0;
        exp_v = pop_exp();
        tests_run++;
        if (out_valid !== 1'b1 || out_adel !== 1'b0 || {out_pc, out_inst} !== exp_v) begin
            tests_failed++;
            $display("FAIL adel_data: got valid=%b adel=%b %h want 1/0 %h", out_valid, out_adel, {out_pc, out_inst}, exp_v);
        end
        d_allowin = 1'b1;
        tick();
        d_allowin = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_flush_wait();
        test_double_flush();
        test_addr_stall();
        test_adel();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_empty: got %0d entries left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
